// File: rtl/laser_pkg.sv
// Shared types and helpers for the laser fire scheduler.
package laser_pkg;

  localparam int PERIOD_W_DEF = 16;
  localparam int PULSE_W_DEF  = 8;
  localparam int SHOT_W_DEF   = 12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ZERO = 2'd1,
    FIRE      = 2'd2,
    GAP       = 2'd3
  } state_e;

  // A zero-length gate is promoted to one cycle so every shot emits light.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

  // The period must leave at least one gate-low cycle between shots.
  function automatic logic [31:0] eff_period(input logic [31:0] period,
                                             input logic [31:0] len);
    return (period > len) ? period : (len + 32'd1);
  endfunction

endpackage

// File: rtl/shot_timer.sv
// Per-shot timer: counts cycles from shot start and drives the laser gate.
module shot_timer #(
  parameter int PERIOD_W = 16,
  parameter int PULSE_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                run_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [PULSE_W-1:0]  len_i,
  output logic                gate_o,
  output logic                pulse_done_o,
  output logic                period_done_o
);

  // cnt_q is 1 in the first cycle of a shot and reaches period_i in its last.
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                gate_q, gate_d;
  logic [PERIOD_W-1:0] len_ext;

  // The gate length is always below the period, so it fits the counter width.
  assign len_ext = PERIOD_W'(len_i);

  // Next count and gate: load restarts the shot, otherwise count while running.
  always_comb begin
    cnt_d  = '0;
    gate_d = 1'b0;
    if (load_i) begin
      cnt_d  = PERIOD_W'(1);
      gate_d = 1'b1;
    end else if (run_i) begin
      cnt_d  = cnt_q + PERIOD_W'(1);
      gate_d = (cnt_q < len_ext);
    end
  end

  // Counter and gate registers; the gate drops at once on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gate_q <= gate_d;
    end
  end

  assign gate_o        = gate_q;
  assign pulse_done_o  = (cnt_q == len_ext);
  assign period_done_o = (cnt_q == period_i);

endmodule

// File: rtl/laser_fire_scheduler.sv
// Laser fire scheduler: one revolution of shots per encoder zero pulse.
//
// state     | meaning
// IDLE      | laser disabled, all outputs low
// WAIT_ZERO | armed, waiting for the revolution index
// FIRE      | laser gate high for the current shot
// GAP       | gate low, waiting for the shot period to elapse
module laser_fire_scheduler
  import laser_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int PULSE_W  = PULSE_W_DEF,
  parameter int SHOT_W   = SHOT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                laser_enable,
  input  logic                zero_pulse,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PULSE_W-1:0]  cfg_pulse_len,
  input  logic [SHOT_W-1:0]   cfg_shots,
  output logic                send_en,
  output logic                laser_gate,
  output logic [SHOT_W-1:0]   shot_idx,
  output logic                rev_done,
  output logic                rev_overrun,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [SHOT_W-1:0]   idx_q, idx_d;
  logic [SHOT_W-1:0]   n_q, n_d;
  logic [PERIOD_W-1:0] p_q, p_d;
  logic [PULSE_W-1:0]  l_q, l_d;
  logic                send_q, send_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                busy_q, busy_d;
  logic                load, run;
  logic                pulse_done, period_done;
  logic [PULSE_W-1:0]  l_eff;
  logic [PERIOD_W-1:0] p_eff;

  assign l_eff = PULSE_W'(eff_len(32'(cfg_pulse_len)));
  assign p_eff = PERIOD_W'(eff_period(32'(cfg_period), 32'(l_eff)));

  shot_timer #(
    .PERIOD_W(PERIOD_W),
    .PULSE_W (PULSE_W)
  ) u_shot_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .run_i        (run),
    .period_i     (p_q),
    .len_i        (l_q),
    .gate_o       (laser_gate),
    .pulse_done_o (pulse_done),
    .period_done_o(period_done)
  );

  // Next state, snapshot, shot index and strobes; zero_pulse beats period end.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    p_d     = p_q;
    l_d     = l_q;
    send_d  = 1'b0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    load    = 1'b0;
    run     = 1'b0;
    if (!laser_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_ZERO;
        WAIT_ZERO, FIRE, GAP: begin
          if (zero_pulse) begin
            ovr_d = (state_q != WAIT_ZERO);
            n_d   = cfg_shots;
            p_d   = p_eff;
            l_d   = l_eff;
            idx_d = '0;
            if (cfg_shots == '0) begin
              state_d = WAIT_ZERO;
              done_d  = (state_q == WAIT_ZERO);
            end else begin
              state_d = FIRE;
              load    = 1'b1;
              send_d  = 1'b1;
            end
          end else if (state_q == FIRE) begin
            run = 1'b1;
            if (pulse_done) state_d = GAP;
          end else if (state_q == GAP) begin
            if (!period_done) begin
              run = 1'b1;
            end else if (idx_q == n_q - SHOT_W'(1)) begin
              done_d  = 1'b1;
              state_d = WAIT_ZERO;
            end else begin
              idx_d   = idx_q + SHOT_W'(1);
              load    = 1'b1;
              send_d  = 1'b1;
              state_d = FIRE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == FIRE) || (state_d == GAP);
  end

  // State, snapshot and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      p_q     <= '0;
      l_q     <= '0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      p_q     <= p_d;
      l_q     <= l_d;
      send_q  <= send_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign send_en     = send_q;
  assign shot_idx    = idx_q;
  assign rev_done    = done_q;
  assign rev_overrun = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_laser_fire_scheduler.sv
// Directed bench for laser_fire_scheduler with a cycle-level reference model.
module tb_laser_fire_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        laser_enable;
  logic        zero_pulse;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_pulse_len;
  logic [11:0] cfg_shots;
  logic        send_en, laser_gate, rev_done, rev_overrun, busy;
  logic [11:0] shot_idx;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int send_log[$];
  int done_log[$];
  int ovr_log[$];

  laser_fire_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .laser_enable (laser_enable),
    .zero_pulse   (zero_pulse),
    .cfg_period   (cfg_period),
    .cfg_pulse_len(cfg_pulse_len),
    .cfg_shots    (cfg_shots),
    .send_en      (send_en),
    .laser_gate   (laser_gate),
    .shot_idx     (shot_idx),
    .rev_done     (rev_done),
    .rev_overrun  (rev_overrun),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: revolution as a list of shots, k = cycles since shot start.
  typedef enum {M_IDLE, M_WAIT, M_ACT} mmode_e;
  mmode_e m_mode = M_IDLE;
  int m_k = 0, m_L = 0, m_P = 0, m_N = 0, m_idx = 0;
  bit m_send = 0, m_done = 0, m_ovr = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = M_IDLE; m_idx = 0; m_k = 0;
      m_send = 0; m_done = 0; m_ovr = 0;
    end else begin
      m_send = 0; m_done = 0; m_ovr = 0;
      if (!laser_enable) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_WAIT;
      else if (zero_pulse) begin
        m_ovr = (m_mode == M_ACT);
        m_L   = (int'(cfg_pulse_len) == 0) ? 1 : int'(cfg_pulse_len);
        m_P   = (int'(cfg_period) > m_L) ? int'(cfg_period) : m_L + 1;
        m_N   = int'(cfg_shots);
        m_idx = 0;
        if (m_N == 0) begin
          m_mode = M_WAIT;
          m_done = !m_ovr;
        end else begin
          m_mode = M_ACT; m_k = 0; m_send = 1;
        end
      end else if (m_mode == M_ACT) begin
        m_k++;
        if (m_k == m_P) begin
          if (m_idx == m_N - 1) begin
            m_done = 1; m_mode = M_WAIT;
          end else begin
            m_idx++; m_k = 0; m_send = 1;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge and log strobe cycles.
  initial forever begin
    logic [16:0] act, exp;
    @(negedge clk);
    act = {send_en, laser_gate, rev_done, rev_overrun, busy, shot_idx};
    exp = {m_send, (m_mode == M_ACT) && (m_k < m_L), m_done, m_ovr,
           m_mode == M_ACT, 12'(m_idx)};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL cycle_compare: {send,gate,done,ovr,busy,idx} got %h, expected %h (cycle %0d)",
                  act, exp, cyc);
    if (send_en)     send_log.push_back(cyc);
    if (rev_done)    done_log.push_back(cyc);
    if (rev_overrun) ovr_log.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    send_log.delete(); done_log.delete(); ovr_log.delete();
  endtask

  task automatic set_cfg(input int per, input int len, input int shots);
    cfg_period = 16'(per); cfg_pulse_len = 8'(len); cfg_shots = 12'(shots);
  endtask

  // Drive one zero pulse at the current cycle t; returns with cycle = t+1.
  task automatic pulse_zero(output int t);
    t = cyc;
    zero_pulse = 1'b1;
    tick(1);
    zero_pulse = 1'b0;
  endtask

  initial begin
    int t0, t1;
    rst = 1'b1; laser_enable = 1'b0; zero_pulse = 1'b0;
    set_cfg(0, 0, 0);
    tick(3);
    check("reset_outputs", {send_en, laser_gate, rev_done, rev_overrun, busy, shot_idx}, 0);
    rst = 1'b0;

    // Basic revolution: P=10, L=3, N=4.
    set_cfg(10, 3, 4);
    laser_enable = 1'b1;
    tick(5);
    clear_logs();
    pulse_zero(t0);
    check("basic_first_gate", laser_gate, 1);
    tick(50);
    check("basic_send_cnt", send_log.size(), 4);
    for (int i = 0; i < 4; i++) check("basic_send_at", send_log[i] - t0, 1 + 10 * i);
    check("basic_done_cnt", done_log.size(), 1);
    check("basic_done_at", done_log[0] - t0, 41);
    check("basic_last_idx", shot_idx, 3);
    check("basic_idle_busy", busy, 0);

    // Clamping: L=1, P=2, N=3.
    set_cfg(1, 0, 3);
    clear_logs();
    pulse_zero(t0);
    tick(12);
    check("clamp_send_cnt", send_log.size(), 3);
    for (int i = 0; i < 3; i++) check("clamp_send_at", send_log[i] - t0, 1 + 2 * i);
    check("clamp_done_at", done_log[0] - t0, 7);

    // Overrun mid-revolution: shot 2, five cycles in.
    set_cfg(10, 3, 8);
    clear_logs();
    pulse_zero(t0);
    tick(24);
    pulse_zero(t1);
    check("ovr_t1", t1 - t0, 25);
    check("ovr_strobe", rev_overrun, 1);
    check("ovr_idx", shot_idx, 0);
    check("ovr_send", send_en, 1);
    tick(85);
    check("ovr_cnt", ovr_log.size(), 1);
    check("ovr_send_restart", send_log[3] - t0, 26);
    check("ovr_done_cnt", done_log.size(), 1);
    check("ovr_done_at", done_log[0] - t1, 81);

    // Overrun coincident with the final period end.
    set_cfg(10, 3, 2);
    clear_logs();
    pulse_zero(t0);
    tick(19);
    pulse_zero(t1);
    check("coinc_ovr", rev_overrun, 1);
    check("coinc_no_done", rev_done, 0);
    tick(25);
    check("coinc_ovr_at", ovr_log[0] - t0, 21);
    check("coinc_done_cnt", done_log.size(), 1);
    check("coinc_done_at", done_log[0] - t0, 41);

    // Config snapshot: period change applies from the next zero pulse.
    set_cfg(10, 3, 4);
    clear_logs();
    pulse_zero(t0);
    tick(5);
    cfg_period = 16'd20;
    tick(40);
    pulse_zero(t1);
    tick(85);
    check("snap_gap_old", send_log[3] - send_log[2], 10);
    check("snap_first_new", send_log[4] - t1, 1);
    check("snap_gap_new", send_log[5] - send_log[4], 20);
    check("snap_done_at", done_log[1] - t1, 81);

    // Disable mid-shot, then re-enable without firing until a zero pulse.
    set_cfg(10, 3, 4);
    clear_logs();
    pulse_zero(t0);
    laser_enable = 1'b0;
    tick(1);
    check("dis_gate", laser_gate, 0);
    check("dis_busy", busy, 0);
    tick(30);
    laser_enable = 1'b1;
    tick(20);
    check("dis_no_send", send_log.size(), 1);
    pulse_zero(t0);
    tick(2);
    check("reen_send", send_log.size(), 2);

    // Asynchronous reset in GAP.
    tick(3);
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1 check("async_rst_outputs",
             {send_en, laser_gate, rev_done, rev_overrun, busy, shot_idx}, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("post_rst_busy", busy, 0);

    // Zero shots: rev_done only.
    set_cfg(10, 3, 0);
    clear_logs();
    pulse_zero(t0);
    check("n0_done", rev_done, 1);
    tick(5);
    check("n0_send_cnt", send_log.size(), 0);
    check("n0_done_cnt", done_log.size(), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
